key_conditioner: RTL

//   Conditions raw active-low push-buttons KEY[3:1] before the Supercar pattern core consumes them as mode requests m1..m3.
//   Per key: 2-flop synchronizer, counter-based debounce, then clean level, press/release pulses and a latched mode select.

---
 rtl/supercar_pkg.sv | 21 ++
 rtl/key_conditioner_if.sv | 21 ++
 rtl/key_debounce_ch.sv | 107 ++++++++++
 rtl/key_conditioner.sv | 62 ++++++
 4 files changed

// File: rtl/supercar_pkg.sv
// Shared definitions for the Supercar front end: key-channel FSM states and
// the mode_sel encoding consumed by the pattern core.
package supercar_pkg;

    typedef enum logic [1:0] {
        UP        = 2'd0,
        PRESS_CHK = 2'd1,
        DOWN      = 2'd2,
        REL_CHK   = 2'd3
    } key_state_e;

    localparam logic [1:0] MODE_NONE = 2'd0;
    localparam logic [1:0] MODE_1    = 2'd1;
    localparam logic [1:0] MODE_2    = 2'd2;
    localparam logic [1:0] MODE_3    = 2'd3;

    function automatic logic [1:0] mode_of_index(input int unsigned idx);
        return 2'(idx + 1);
    endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Button bundle between the raw KEY pins, the conditioner and its consumer.
interface key_conditioner_if #(
    parameter int N_KEYS = 3
) ();
    logic [N_KEYS-1:0] key_n;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [1:0]        mode_sel;
    logic              mode_valid;

    modport master (
        output key_n,
        input  key_level, key_press, key_release, mode_sel, mode_valid
    );

    modport slave (
        input  key_n,
        output key_level, key_press, key_release, mode_sel, mode_valid
    );
endinterface

// File: rtl/key_debounce_ch.sv
// One button channel: 2-flop synchronizer, counter debounce FSM, registered
// level and press/release pulses.
module key_debounce_ch
    import supercar_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic press_accept
);
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             s;

    assign sync_d = {sync_q[0], key_raw_n};
    assign s      = ~sync_q[1];

    // >= rather than == so DEB_CYCLES=1 still accepts on the first check cycle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            UP: begin
                if (s) begin
                    state_d = PRESS_CHK;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_CHK: begin
                if (!s) begin
                    state_d = UP;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DOWN: begin
                if (!s) begin
                    state_d = REL_CHK;
                    cnt_d   = CNT_ONE;
                end
            end
            REL_CHK: begin
                if (s) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d   = UP;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = UP;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '1;
            state_q   <= UP;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign key_level    = level_q;
    assign key_press    = press_q;
    assign key_release  = release_q;
    assign press_accept = press_d;

endmodule

// File: rtl/key_conditioner.sv
// Conditions active-low KEY[N_KEYS:1] into clean levels, pulses and a latched
// mode select; the lowest-index key accepted in a cycle sets mode_sel.
module key_conditioner
    import supercar_pkg::*;
#(
    parameter int N_KEYS     = 3,
    parameter int DEB_CYCLES = 4
) (
    input  logic              CLOCK_50,
    input  logic              rst_n,
    key_conditioner_if.slave  kbus
);
    logic [N_KEYS-1:0] level_w, press_w, release_w, accept_w;
    logic [1:0]        mode_sel_q, mode_sel_d;
    logic              mode_valid_q, mode_valid_d;
    logic              found;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_ch (
            .clk          (CLOCK_50),
            .rst_n        (rst_n),
            .key_raw_n    (kbus.key_n[i]),
            .key_level    (level_w[i]),
            .key_press    (press_w[i]),
            .key_release  (release_w[i]),
            .press_accept (accept_w[i])
        );
    end

    // Uses the channels' pre-register accept so mode_sel lands with key_press
    always_comb begin
        mode_sel_d   = mode_sel_q;
        mode_valid_d = 1'b0;
        found        = 1'b0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            if (accept_w[i] && !found) begin
                mode_sel_d   = mode_of_index(i);
                mode_valid_d = 1'b1;
                found        = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            mode_sel_q   <= MODE_NONE;
            mode_valid_q <= 1'b0;
        end else begin
            mode_sel_q   <= mode_sel_d;
            mode_valid_q <= mode_valid_d;
        end
    end

    assign kbus.key_level   = level_w;
    assign kbus.key_press   = press_w;
    assign kbus.key_release = release_w;
    assign kbus.mode_sel    = mode_sel_q;
    assign kbus.mode_valid  = mode_valid_q;

endmodule
